// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, stall
// encoding and bit positions of the fields in the EX->MEM bus.
package mem_stage_pkg;

   localparam int EX_TO_MEM_WD = 76;
   localparam int MEM_TO_WB_WD = 70;
   localparam int MEM_TO_RF_WD = 38;
   localparam int LOAD_W       = 5;
   localparam int STALL_W      = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam int STALL_MEM = 3;
   localparam int STALL_WB  = 4;

   // ex_to_mem_bus field positions
   localparam int PC_HI       = 75;
   localparam int PC_LO       = 44;
   localparam int RAM_EN      = 43;
   localparam int RAM_WEN_HI  = 42;
   localparam int RAM_WEN_LO  = 39;
   localparam int SEL_RF_RES  = 38;
   localparam int RF_WE       = 37;
   localparam int RF_WADDR_HI = 36;
   localparam int RF_WADDR_LO = 32;
   localparam int RESULT_HI   = 31;

   // ex_load_bus bit positions, {lb, lbu, lh, lhu, lw}
   localparam int LD_LB  = 4;
   localparam int LD_LBU = 3;
   localparam int LD_LH  = 2;
   localparam int LD_LHU = 1;
   localparam int LD_LW  = 0;

   typedef enum logic [1:0] {
      RD_EMPTY = 2'd0,
      RD_FRESH = 2'd1,
      RD_HELD  = 2'd2
   } rd_state_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// load_ext: selects the addressed byte/halfword of a 32-bit load word and
// sign- or zero-extends it.
//   i_rdata  in  32  word returned by the data SRAM
//   i_off    in  2   byte offset (ex_result[1:0])
//   i_load   in  5   {lb, lbu, lh, lhu, lw}, one-hot or zero
//   o_data   out 32  extended result (full word when no flag is set)
module load_ext
   import mem_stage_pkg::*;
(
   input  logic [31:0]       i_rdata,
   input  logic [1:0]        i_off,
   input  logic [LOAD_W-1:0] i_load,
   output logic [31:0]       o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_off)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   // off[0] is deliberately ignored for halfwords; misalignment is not trapped here.
   assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_data = i_rdata;
      if (i_load[LD_LB])
         o_data = {{24{w_byte[7]}}, w_byte};
      else if (i_load[LD_LBU])
         o_data = {24'd0, w_byte};
      else if (i_load[LD_LH])
         o_data = {{16{w_half[15]}}, w_half};
      else if (i_load[LD_LHU])
         o_data = {16'd0, w_half};
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage downstream of EX.
// Registers the EX->MEM bus and load flags, extends the SRAM load data and
// drives the MEM->WB bus and the MEM->ID forwarding bus.
//   clk, rst           clock, synchronous active-high reset
//   stall              stall vector, bit 3 holds MEM, bit 4 holds WB
//   ex_to_mem_bus      {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_load_bus        {lb, lbu, lh, lhu, lw}
//   data_sram_rdata    SRAM read data, valid only in a load's first MEM cycle
//   mem_to_wb_bus      {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_rf_bus      {rf_we, rf_waddr, rf_wdata}
//
//   state    | meaning
//   RD_EMPTY | no load in MEM (non-load, bubble or reset)
//   RD_FRESH | load in its first MEM cycle; SRAM rdata is live
//   RD_HELD  | load stalled past its first cycle; use r_rdata_hold
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int EX_TO_MEM_WD_P = EX_TO_MEM_WD,
   parameter int MEM_TO_WB_WD_P = MEM_TO_WB_WD,
   parameter int MEM_TO_RF_WD_P = MEM_TO_RF_WD,
   parameter int LOAD_W_P       = LOAD_W,
   parameter int STALL_W_P      = STALL_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [STALL_W_P-1:0]      stall,
   input  logic [EX_TO_MEM_WD_P-1:0] ex_to_mem_bus,
   input  logic [LOAD_W_P-1:0]       ex_load_bus,
   input  logic [31:0]               data_sram_rdata,
   output logic [MEM_TO_WB_WD_P-1:0] mem_to_wb_bus,
   output logic [MEM_TO_RF_WD_P-1:0] mem_to_rf_bus
);

   logic [EX_TO_MEM_WD_P-1:0] r_bus;
   logic [LOAD_W_P-1:0]       r_load;
   logic [31:0]               r_rdata_hold;
   rd_state_t                 r_state;
   rd_state_t                 w_state_nxt;

   logic        w_capture;
   logic        w_bubble;
   logic        w_hold;
   logic [31:0] w_load_src;
   logic [31:0] w_load_ext;
   logic [31:0] w_rf_wdata;
   logic        w_unused;

   assign w_capture = (stall[STALL_MEM] == NO_STOP);
   assign w_bubble  = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);
   assign w_hold    = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == STOP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bus  <= '0;
         r_load <= '0;
      end else if (w_bubble) begin
         r_bus  <= '0;
         r_load <= '0;
      end else if (w_capture) begin
         r_bus  <= ex_to_mem_bus;
         r_load <= ex_load_bus;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= RD_EMPTY;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_capture)
         w_state_nxt = ex_to_mem_bus[SEL_RF_RES] ? RD_FRESH : RD_EMPTY;
      else if (w_bubble)
         w_state_nxt = RD_EMPTY;
      else if (r_state == RD_FRESH)
         w_state_nxt = RD_HELD;
   end

   // The SRAM drives rdata for one cycle only, so grab it on the edge that
   // turns a fresh load into a held one.
   always_ff @(posedge clk) begin
      if (rst)
         r_rdata_hold <= '0;
      else if ((r_state == RD_FRESH) && w_hold)
         r_rdata_hold <= data_sram_rdata;
   end

   assign w_load_src = (r_state == RD_HELD) ? r_rdata_hold : data_sram_rdata;

   load_ext u_load_ext (
      .i_rdata (w_load_src),
      .i_off   (r_bus[1:0]),
      .i_load  (r_load),
      .o_data  (w_load_ext)
   );

   assign w_rf_wdata = r_bus[SEL_RF_RES] ? w_load_ext : r_bus[RESULT_HI:0];

   assign mem_to_wb_bus = {r_bus[PC_HI:PC_LO], r_bus[RF_WE],
                           r_bus[RF_WADDR_HI:RF_WADDR_LO], w_rf_wdata};
   assign mem_to_rf_bus = {r_bus[RF_WE], r_bus[RF_WADDR_HI:RF_WADDR_LO], w_rf_wdata};

   // SRAM control fields and the other stall bits are consumed elsewhere.
   assign w_unused = ^{r_bus[RAM_EN:RAM_WEN_LO], stall[STALL_W_P-1:STALL_WB+1],
                       stall[STALL_MEM-1:0]};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [75:0] bus;
   logic [4:0]  ld;
   logic [31:0] rdata;
   logic [69:0] wb;
   logic [37:0] rf;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .ex_to_mem_bus   (bus),
      .ex_load_bus     (ld),
      .data_sram_rdata (rdata),
      .mem_to_wb_bus   (wb),
      .mem_to_rf_bus   (rf)
   );

   // Reference model: the instruction sitting in MEM, and the word its load
   // returned, taken from the SRAM during the instruction's first MEM cycle.
   logic [75:0] m_bus   = '0;
   logic [4:0]  m_ld    = '0;
   bit          m_first = 0;
   logic [31:0] m_word  = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_bus = '0; m_ld = '0; m_first = 0;
      end else if (stall[3] && !stall[4]) begin
         m_bus = '0; m_ld = '0; m_first = 0;
      end else if (!stall[3]) begin
         m_bus = bus; m_ld = ld; m_first = bus[38];
      end else begin
         m_first = 0;
      end
   end

   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [4:0] l);
      int v;
      if (l[4] || l[3]) begin
         v = int'((w >> (8 * off)) & 32'hFF);
         if (l[4] && v > 127) v = v - 256;
      end else if (l[2] || l[1]) begin
         v = int'((w >> (16 * off[1])) & 32'hFFFF);
         if (l[2] && v > 32767) v = v - 65536;
      end else begin
         return w;
      end
      return 32'(v);
   endfunction

   task automatic check(input string name, input logic [69:0] got, input logic [69:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
   endtask

   always @(negedge clk) begin : compare
      logic [31:0] wd;
      logic [69:0] e;
      if (chk_en) begin
         if (m_first) m_word = rdata;
         wd = m_bus[38] ? exp_load(m_word, m_bus[1:0], m_ld) : m_bus[31:0];
         e  = {m_bus[75:44], m_bus[37], m_bus[36:32], wd};
         check("wb_bus", wb, e);
         check("rf_bus", {32'd0, rf}, {32'd0, e[37:0]});
      end
   end

   function automatic logic [75:0] mk(input logic [31:0] pc, input logic sel, input logic we,
                                      input logic [4:0] wa, input logic [31:0] res);
      return {pc, sel, 4'd0, sel, we, wa, res};
   endfunction

   task automatic cyc(input logic r, input logic [5:0] s, input logic [75:0] b,
                      input logic [4:0] l, input logic [31:0] d);
      @(posedge clk);
      #1;
      rst = r; stall = s; bus = b; ld = l; rdata = d;
      @(negedge clk);
      #1;
   endtask

   localparam logic [4:0] LB = 5'b10000, LBU = 5'b01000, LH = 5'b00100,
                          LHU = 5'b00010, LW = 5'b00001;
   localparam logic [5:0] HOLD = 6'b011000, BUB = 6'b001000;

   initial begin
      logic [75:0] rb;
      logic [4:0]  rl;
      logic [5:0]  rs;
      rst = 1'b1; stall = '0; bus = '0; ld = '0; rdata = '0;
      @(posedge clk);
      #1;
      chk_en = 1;
      @(negedge clk);
      #1;
      check("reset_wb", wb, 70'd0);
      check("reset_rf", {32'd0, rf}, 70'd0);

      // ALU passthrough
      cyc(0, 6'd0, mk(32'h100, 0, 1, 5'd5, 32'h0000_1234), 5'd0, 32'h5555_AAAA);
      cyc(0, 6'd0, 76'd0, 5'd0, 32'h0);
      check("alu_wb", wb, {32'h100, 1'b1, 5'd5, 32'h0000_1234});
      check("alu_rf", {32'd0, rf}, {32'd0, 1'b1, 5'd5, 32'h0000_1234});

      // lb / lbu at off=3
      cyc(0, 6'd0, mk(32'h104, 1, 1, 5'd3, 32'h1003), LB, 32'h0);
      cyc(0, 6'd0, mk(32'h108, 1, 1, 5'd4, 32'h1003), LBU, 32'h80FF_0011);
      check("lb", {38'd0, wb[31:0]}, {38'd0, 32'hFFFF_FF80});
      cyc(0, 6'd0, 76'd0, 5'd0, 32'h80FF_0011);
      check("lbu", {38'd0, wb[31:0]}, {38'd0, 32'h0000_0080});

      // lh off=2, lhu off=0, lw
      cyc(0, 6'd0, mk(32'h10C, 1, 1, 5'd6, 32'h2002), LH, 32'h0);
      cyc(0, 6'd0, mk(32'h110, 1, 1, 5'd7, 32'h2000), LHU, 32'h8001_7FFF);
      check("lh", {38'd0, wb[31:0]}, {38'd0, 32'hFFFF_8001});
      cyc(0, 6'd0, mk(32'h114, 1, 1, 5'd8, 32'h2000), LW, 32'h8001_7FFF);
      check("lhu", {38'd0, wb[31:0]}, {38'd0, 32'h0000_7FFF});
      cyc(0, 6'd0, 76'd0, 5'd0, 32'h8001_7FFF);
      check("lw", {38'd0, wb[31:0]}, {38'd0, 32'h8001_7FFF});

      // lw held across a 3-cycle stall while rdata changes
      cyc(0, 6'd0, mk(32'h118, 1, 1, 5'd9, 32'h3000), LW, 32'h0);
      cyc(0, HOLD, 76'd0, 5'd0, 32'h1122_3344);
      check("stall_first", {38'd0, wb[31:0]}, {38'd0, 32'h1122_3344});
      for (int i = 0; i < 3; i++) begin
         cyc(0, HOLD, mk(32'h999, 1, 1, 5'd1, 32'h0), LB, 32'hDEAD_BEEF);
         check("stall_held", {38'd0, wb[31:0]}, {38'd0, 32'h1122_3344});
      end

      // bubble: MEM stopped, WB running
      cyc(0, BUB, 76'd0, 5'd0, 32'hDEAD_BEEF);
      cyc(0, 6'd0, 76'd0, 5'd0, 32'h1);
      check("bubble_wb", wb, 70'd0);
      check("bubble_we", {69'd0, rf[37]}, 70'd0);

      // reset while HELD, then a fresh lw
      cyc(0, 6'd0, mk(32'h11C, 1, 1, 5'd10, 32'h4000), LW, 32'h0);
      cyc(0, HOLD, 76'd0, 5'd0, 32'hAAAA_5555);
      cyc(0, HOLD, 76'd0, 5'd0, 32'h0);
      check("held_pre_rst", {38'd0, wb[31:0]}, {38'd0, 32'hAAAA_5555});
      cyc(1, HOLD, 76'd0, 5'd0, 32'h0);
      cyc(0, HOLD, 76'd0, 5'd0, 32'hDEAD_BEEF);
      check("rst_held", wb, 70'd0);
      cyc(0, 6'd0, mk(32'h120, 1, 1, 5'd11, 32'h4000), LW, 32'h0);
      cyc(0, 6'd0, 76'd0, 5'd0, 32'hCAFE_F00D);
      check("post_rst_lw", {38'd0, wb[31:0]}, {38'd0, 32'hCAFE_F00D});

      // randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         rb = {$urandom, $urandom, 12'($urandom)};
         rb[38] = 1'($urandom_range(0, 1));
         rl = 5'd0;
         if (rb[38]) begin
            case ($urandom_range(0, 5))
               0: rl = LB;  1: rl = LBU; 2: rl = LH;
               3: rl = LHU; 4: rl = LW;  default: rl = 5'd0;
            endcase
         end
         rs = 6'($urandom);
         rs[3] = ($urandom_range(0, 99) < 45);
         cyc(($urandom_range(0, 99) < 2), rs, rb, rl, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of EX.
- Registers the EX→MEM bus and the EX load-type flags.
- Extracts and extends load data returned by the synchronous data SRAM, selects the final register write value, and drives the MEM→WB bus plus the MEM forwarding bus to ID.
- Preserves SRAM read data across stall cycles, because the SRAM presents rdata for only one cycle after the request.

Parameters:
- EX_TO_MEM_WD, 76, width of ex_to_mem_bus.
- MEM_TO_WB_WD, 70, width of mem_to_wb_bus.
- MEM_TO_RF_WD, 38, width of mem_to_rf_bus.
- LOAD_W, 5, width of the load-type flag bus.
- STALL_W, 6, width of the stall bus.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- stall  in  STALL_W  pipeline stall vector; 1 = Stop. Bit 3 holds MEM, bit 4 holds WB.
- ex_to_mem_bus  in  EX_TO_MEM_WD  fields: {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- ex_load_bus  in  LOAD_W  {lb, lbu, lh, lhu, lw}, one-hot or zero.
- data_sram_rdata  in  32  SRAM read data; valid in the first cycle the load occupies MEM.
- mem_to_wb_bus  out  MEM_TO_WB_WD  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_rf_bus  out  MEM_TO_RF_WD  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}; forwarding path to ID.

Behaviour:
- Input register update, on the rising clk edge, in priority order:
  - rst: clear bus_r and load_r.
  - stall[3]=Stop and stall[4]=NoStop: insert a bubble (clear both registers).
  - stall[3]=NoStop: capture ex_to_mem_bus and ex_load_bus.
  - otherwise: hold.
- Read-data state machine. States: EMPTY, FRESH, HELD. Reset state is EMPTY.
  - Any register capture of a load (sel_rf_res=1) → FRESH.
  - Capture of a non-load, or a bubble → EMPTY.
  - FRESH with the register held → HELD. On that same edge, rdata_hold ← data_sram_rdata.
  - HELD stays HELD while the register is held.
  - HELD or FRESH with a new capture → FRESH or EMPTY, per the incoming instruction.
- Load data source: data_sram_rdata in FRESH, rdata_hold in HELD. Never read the live rdata in HELD.
- Byte/halfword extraction, using off = ex_result[1:0]:
  - lb/lbu: byte = rdata[8*off+7 : 8*off]; lb sign-extends, lbu zero-extends.
  - lh/lhu: half = off[1] ? rdata[31:16] : rdata[15:0]; lh sign-extends, lhu zero-extends. off[0] is ignored (no alignment exception here).
  - lw: full word.
  - sel_rf_res=1 with all flags zero: full word.
- rf_wdata = sel_rf_res ? extended load data : ex_result.
- Outputs are combinational from registered state. The stage adds 1 cycle of latency.
- Reset values: all output buses 0; rdata_hold 0.
- Bubble behaviour: rf_we=0, so ID forwarding never matches.
- Reset mid-stall: clears to EMPTY and discards rdata_hold.
- Simultaneous capture and FRESH: the new instruction wins; the old rdata is not needed.

Decomposition:
- Shared defines header: bus widths, Stop/NoStop, the StallBus width, and the field bit positions listed above.
- One natural sub-module, load_ext (combinational): inputs rdata, off, load flags; output the extended 32-bit word.

Test Plan:
- ALU passthrough: add result 0x0000_1234, rf_we=1, waddr=5 → next cycle mem_to_wb rf_wdata=0x1234 and mem_to_rf identical.
- lb at off=3, rdata=0x80FF_0011 → rf_wdata=0xFFFF_FF80. lbu, same input → 0x0000_0080.
- lh at off=2, rdata=0x8001_7FFF → 0xFFFF_8001. lhu at off=0 → 0x0000_7FFF. lw → 0x8001_7FFF.
- lw, then stall[3]=stall[4]=Stop for 3 cycles while rdata changes to 0xDEAD_BEEF → rf_wdata stays the first-cycle value 0x1122_3344 throughout.
- stall[3]=Stop, stall[4]=NoStop → next cycle bus is all zero and rf_we=0.
- rst asserted while in HELD → next cycle outputs 0 and state EMPTY. A subsequent lw uses fresh rdata.
